// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, Funct3 size codes, access check.
// Imported by the LSU top and its load-extension helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic access_err(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = rd & wr;
    unique case (f3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: bad = bad | off[0];
      F3_W:        bad = bad | (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data memory bus between the LSU (master) and memory (slave).
// Request side: MemReq/MemWe/MemAddr/MemWData/MemBe; reply: MemReady/MemRData.
interface load_store_unit_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  MemReq;
  logic                  MemWe;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0]      MemWData;
  logic [3:0]            MemBe;
  logic                  MemReady;
  logic [WIDTH-1:0]      MemRData;

  modport master (
    output MemReq, MemWe, MemAddr,
    output MemWData, MemBe,
    input  MemReady, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr,
    input  MemWData, MemBe,
    output MemReady, MemRData
  );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane of a read word and sign/zero extends.
// Ports: rdata_i word, off_i byte offset, funct3_i size/sign, data_o result.
module load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [1:0]       off_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = rdata_i[{off_i[1], 4'b0000} +: 16];
    unique case (funct3_i)
      F3_B:    data_o = {{(WIDTH-8){b[7]}}, b};
      F3_H:    data_o = {{(WIDTH-16){h[15]}}, h};
      F3_BU:   data_o = {{(WIDTH-8){1'b0}}, b};
      F3_HU:   data_o = {{(WIDTH-16){1'b0}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: IDLE->REQ->DONE bus sequencer with pipeline stall.
// Ports: clk/rst, M-stage controls in, ReadDataM/StallM/ErrM out, bus master.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0]      WriteDataM,
  output logic [WIDTH-1:0]      ReadDataM,
  output logic                  StallM,
  output logic                  ErrM,
  load_store_unit_if.master     bus
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  logic             access;
  logic             err;
  logic             start;
  logic [WIDTH-1:0] ext;
  logic [3:0]       be_st;
  logic [WIDTH-1:0] wd_st;

  assign access = MemReadM | MemWriteM;
  assign err    = access_err(MemReadM, MemWriteM,
                             Funct3M, ALUResultM[1:0]);
  assign start  = access & ~err;

  load_extend #(
    .WIDTH(WIDTH)
  ) u_ext (
    .rdata_i (bus.MemRData),
    .off_i   (addr_q[1:0]),
    .funct3_i(f3_q),
    .data_o  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // The access is latched on entry to REQ so the bus stays
  // stable regardless of what the M-stage inputs do meanwhile.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          addr_d  = ALUResultM;
          wdata_d = WriteDataM;
          f3_d    = Funct3M;
          we_d    = MemWriteM;
        end
      end
      REQ: begin
        if (bus.MemReady) begin
          state_d = DONE;
          rdata_d = we_q ? '0 : ext;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (f3_q[1:0])
      2'b00: begin
        be_st = 4'b0001 << addr_q[1:0];
        wd_st = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_st = 4'b0011 << addr_q[1:0];
        wd_st = {2{wdata_q[15:0]}};
      end
      default: begin
        be_st = 4'b1111;
        wd_st = wdata_q;
      end
    endcase
  end

  always_comb begin
    ReadDataM    = '0;
    StallM       = 1'b0;
    ErrM         = 1'b0;
    bus.MemReq   = 1'b0;
    bus.MemWe    = 1'b0;
    bus.MemAddr  = '0;
    bus.MemWData = '0;
    bus.MemBe    = 4'b0000;
    unique case (1'b1)
      (state_q == IDLE): begin
        StallM = start;
        ErrM   = access & err;
      end
      (state_q == REQ): begin
        StallM       = 1'b1;
        bus.MemReq   = 1'b1;
        bus.MemWe    = we_q;
        bus.MemAddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.MemBe    = we_q ? be_st : 4'b1111;
        bus.MemWData = we_q ? wd_st : '0;
      end
      (state_q == DONE): ReadDataM = rdata_q;
      default: ;
    endcase
  end

endmodule
